// File: rtl/borrow_sel_sub_pipe_if.sv
// Operand/result handshake bundle for the pipelined borrow-select subtractor.
// The operand source and result consumer sit on the master side; the subtractor uses the slave side.
interface borrow_sel_sub_pipe_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   diff;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff
    );
endinterface

// File: rtl/borrow_sel_sub_pipe.sv
// Two-stage borrow-select subtractor: diff = {bout, a - b - bin}.
// Stage 1 computes the low block and both speculative high blocks from
// full-subtractor cells; stage 2 picks the high block using the low borrow.
module borrow_sel_sub_pipe #(
    parameter int WIDTH = 4,
    parameter int SPLIT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    borrow_sel_sub_pipe_if.slave  bus
);
    localparam int HI = WIDTH - SPLIT;

    // One full-subtractor cell, returned as {borrow_out, difference}.
    function automatic logic [1:0] fsub(input logic x, input logic y, input logic bi);
        return {(~x & y) | (~x & bi) | (y & bi), x ^ y ^ bi};
    endfunction

    logic             s1_valid;
    logic [SPLIT-1:0] dl_q;
    logic             bl_q;
    logic [HI-1:0]    dh0_q;
    logic             bh0_q;
    logic [HI-1:0]    dh1_q;
    logic             bh1_q;
    logic             out_valid_q;
    logic [WIDTH:0]   diff_q;

    logic [SPLIT-1:0] dl_c;
    logic             bl_c;
    logic [HI-1:0]    dh0_c;
    logic             bh0_c;
    logic [HI-1:0]    dh1_c;
    logic             bh1_c;

    logic s2_free;
    logic in_fire;
    logic s1_adv;

    assign s2_free       = !out_valid_q || bus.out_ready;
    assign bus.in_ready  = !s1_valid || s2_free;
    assign in_fire       = bus.in_valid && bus.in_ready;
    assign s1_adv        = s1_valid && s2_free;
    assign bus.out_valid = out_valid_q;
    assign bus.diff      = diff_q;

    // Ripple the low block from bin, and the high block twice (borrow-in 0 and 1).
    always_comb begin
        logic [1:0] r;
        logic       bw;
        logic       bw0;
        logic       bw1;
        dl_c  = '0;
        dh0_c = '0;
        dh1_c = '0;
        r     = '0;
        bw    = bus.bin;
        bw0   = 1'b0;
        bw1   = 1'b1;
        for (int i = 0; i < SPLIT; i++) begin
            r       = fsub(bus.a[i], bus.b[i], bw);
            dl_c[i] = r[0];
            bw      = r[1];
        end
        for (int j = 0; j < HI; j++) begin
            r        = fsub(bus.a[SPLIT+j], bus.b[SPLIT+j], bw0);
            dh0_c[j] = r[0];
            bw0      = r[1];
            r        = fsub(bus.a[SPLIT+j], bus.b[SPLIT+j], bw1);
            dh1_c[j] = r[0];
            bw1      = r[1];
        end
        bl_c  = bw;
        bh0_c = bw0;
        bh1_c = bw1;
    end

    // Stage 1: capture the partial differences when an operand beat is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            dl_q     <= '0;
            bl_q     <= 1'b0;
            dh0_q    <= '0;
            bh0_q    <= 1'b0;
            dh1_q    <= '0;
            bh1_q    <= 1'b0;
        end else begin
            if (in_fire) begin
                s1_valid <= 1'b1;
                dl_q     <= dl_c;
                bl_q     <= bl_c;
                dh0_q    <= dh0_c;
                bh0_q    <= bh0_c;
                dh1_q    <= dh1_c;
                bh1_q    <= bh1_c;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Stage 2: select the high block by the low borrow; hold while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            diff_q      <= '0;
        end else begin
            if (s1_adv) begin
                out_valid_q <= 1'b1;
                diff_q      <= bl_q ? {bh1_q, dh1_q, dl_q} : {bh0_q, dh0_q, dl_q};
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_borrow_sel_sub_pipe.sv
// Directed and exhaustive bench for borrow_sel_sub_pipe (WIDTH=4, SPLIT=2).
module tb_borrow_sel_sub_pipe;
    logic clk;
    logic rst_n;

    borrow_sel_sub_pipe_if #(.WIDTH(4)) bus ();

    borrow_sel_sub_pipe #(.WIDTH(4), .SPLIT(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_pops   = 0;
    logic [4:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle at the negedge, sample just after, and score any result handshake.
    task automatic cycle(input logic iv, input logic [3:0] aa, input logic [3:0] bb,
                         input logic bi, input logic ordy, output logic accepted);
        logic [4:0] e;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.a         = aa;
        bus.b         = bb;
        bus.bin       = bi;
        bus.out_ready = ordy;
        #1;
        accepted = iv && bus.in_ready;
        if (bus.out_valid && ordy) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", {31'd0, bus.out_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("diff", {27'd0, bus.diff}, {27'd0, e});
                n_pops++;
            end
        end
    endtask

    task automatic send(input logic [3:0] aa, input logic [3:0] bb, input logic bi,
                        input logic [4:0] e, input bit rnd);
        logic acc;
        logic iv;
        logic ordy;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 64) begin
            iv   = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            ordy = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            cycle(iv, aa, bb, bi, ordy, acc);
            if (acc) exp_q.push_back(e);
            tries++;
        end
        if (!acc) chk("send_timeout", {31'd0, acc}, 32'd1);
    endtask

    task automatic drain();
        logic acc;
        int   n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, acc);
            n++;
        end
        chk("drain_timeout", exp_q.size(), 32'd0);
    endtask

    initial begin
        logic acc;
        int   p0;
        logic [4:0] e;

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_diff", {27'd0, bus.diff}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Latency: 9 - 3 - 0
        cycle(1'b1, 4'd9, 4'd3, 1'b0, 1'b1, acc);
        chk("lat_accept", {31'd0, acc}, 32'd1);
        exp_q.push_back(5'b00110);
        cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, acc);
        chk("lat_cycle1", {31'd0, bus.out_valid}, 32'd0);
        cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, acc);
        chk("lat_cycle2", {31'd0, bus.out_valid}, 32'd1);
        chk("lat_diff", {27'd0, bus.diff}, 32'b00110);
        drain();

        // Directed values including boundaries and low-block borrow select.
        send(4'd3,  4'd9,  1'b0, 5'b11010, 1'b0);
        send(4'd0,  4'd15, 1'b1, 5'b10000, 1'b0);
        send(4'd4,  4'd3,  1'b1, 5'b00000, 1'b0);
        send(4'd8,  4'd1,  1'b0, 5'b00111, 1'b0);
        send(4'd15, 4'd0,  1'b0, 5'b01111, 1'b0);
        send(4'd7,  4'd7,  1'b0, 5'b00000, 1'b0);
        drain();

        // Back-to-back stream: three results within five cycles means consecutive outputs.
        p0 = n_pops;
        send(4'd5,  4'd2,  1'b0, 5'b00011, 1'b0);
        send(4'd1,  4'd1,  1'b1, 5'b11111, 1'b0);
        send(4'd15, 4'd15, 1'b0, 5'b00000, 1'b0);
        cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, acc);
        cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, acc);
        chk("b2b_count", n_pops - p0, 32'd3);

        // Backpressure: two beats fill the pipe, the third waits.
        cycle(1'b1, 4'd6, 4'd1, 1'b0, 1'b0, acc);
        chk("bp_acc1", {31'd0, acc}, 32'd1);
        exp_q.push_back(5'b00101);
        cycle(1'b1, 4'd2, 4'd5, 1'b0, 1'b0, acc);
        chk("bp_acc2", {31'd0, acc}, 32'd1);
        exp_q.push_back(5'b11101);
        cycle(1'b1, 4'd12, 4'd4, 1'b1, 1'b0, acc);
        chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("bp_hold_diff0", {27'd0, bus.diff}, 32'b00101);
        cycle(1'b1, 4'd12, 4'd4, 1'b1, 1'b0, acc);
        cycle(1'b1, 4'd12, 4'd4, 1'b1, 1'b0, acc);
        chk("bp_still_blocked", {31'd0, acc}, 32'd0);
        chk("bp_hold_diff1", {27'd0, bus.diff}, 32'b00101);
        chk("bp_hold_valid1", {31'd0, bus.out_valid}, 32'd1);
        cycle(1'b1, 4'd12, 4'd4, 1'b1, 1'b1, acc);
        chk("bp_acc3", {31'd0, acc}, 32'd1);
        exp_q.push_back(5'b00111);
        drain();

        // Reset with two beats in flight.
        cycle(1'b1, 4'd10, 4'd3, 1'b0, 1'b0, acc);
        cycle(1'b1, 4'd11, 4'd3, 1'b0, 1'b0, acc);
        cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, acc);
        chk("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_diff", {27'd0, bus.diff}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, acc);
            chk("post_rst_no_stale", {31'd0, bus.out_valid}, 32'd0);
        end

        // Exhaustive with random stalls on both sides.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    e = 5'((ia - ib - ic) & 31);
                    send(4'(ia), 4'(ib), 1'(ic), e, 1'b1);
                end
            end
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
